// File: rtl/ls_unit_pkg.sv
// Shared types, opcode map and helpers for the load/store unit.
// Opcodes are numbered loads first, so one compare against OPENUM_LHU separates loads from stores.
package ls_unit_pkg;
  localparam int OPENUM_W = 6;

  typedef logic [31:0] DATA_TYPE;
  typedef logic [31:0] ADDR_TYPE;
  typedef logic [3:0]  ROB_ID_TYPE;

  localparam ROB_ID_TYPE ZERO_ROB  = '0;
  localparam DATA_TYPE   ZERO_WORD = '0;

  localparam logic [OPENUM_W-1:0] OPENUM_LB  = 6'd0;
  localparam logic [OPENUM_W-1:0] OPENUM_LH  = 6'd1;
  localparam logic [OPENUM_W-1:0] OPENUM_LW  = 6'd2;
  localparam logic [OPENUM_W-1:0] OPENUM_LBU = 6'd3;
  localparam logic [OPENUM_W-1:0] OPENUM_LHU = 6'd4;
  localparam logic [OPENUM_W-1:0] OPENUM_SB  = 6'd5;
  localparam logic [OPENUM_W-1:0] OPENUM_SH  = 6'd6;
  localparam logic [OPENUM_W-1:0] OPENUM_SW  = 6'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    RESULT   = 2'd2
  } state_e;

  function automatic logic is_load(input logic [OPENUM_W-1:0] op);
    return op <= OPENUM_LHU;
  endfunction

  function automatic logic [2:0] op_size(input logic [OPENUM_W-1:0] op);
    case (op)
      OPENUM_LB, OPENUM_LBU, OPENUM_SB: return 3'd1;
      OPENUM_LH, OPENUM_LHU, OPENUM_SH: return 3'd2;
      default:                          return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/ls_extend.sv
// Combinational load-data extender: sign/zero-extends raw right-aligned memory data by opcode.
module ls_extend
  import ls_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OPENUM_W-1:0] openum_i,
  input  logic [DATA_W-1:0]   raw_i,
  output logic [DATA_W-1:0]   result_o
);
  always_comb begin
    result_o = raw_i;
    case (openum_i)
      OPENUM_LB:  result_o = {{(DATA_W-8){raw_i[7]}}, raw_i[7:0]};
      OPENUM_LH:  result_o = {{(DATA_W-16){raw_i[15]}}, raw_i[15:0]};
      OPENUM_LBU: result_o = {{(DATA_W-8){1'b0}}, raw_i[7:0]};
      OPENUM_LHU: result_o = {{(DATA_W-16){1'b0}}, raw_i[15:0]};
      default:    result_o = raw_i;
    endcase
  end
endmodule

// File: rtl/ls_unit.sv
// Single-slot load/store unit: takes one LSB request, runs it on the memory controller,
// and broadcasts extended load data on the LS CDB. Handshake: a request is taken only when
// enable_from_lsb is high while busy_to_lsb would otherwise be low (IDLE, no rollback).
module ls_unit
  import ls_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                enable_from_lsb,
  input  logic [OPENUM_W-1:0] openum_from_lsb,
  input  logic [ADDR_W-1:0]   addr_from_lsb,
  input  logic [DATA_W-1:0]   store_data_from_lsb,
  input  logic [ROB_ID_W-1:0] rob_id_from_lsb,
  output logic                busy_to_lsb,
  input  logic                rollback,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [2:0]          mem_size,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_done,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_result,
  output state_e              dbg_state
);
  state_e                state_q;
  logic [OPENUM_W-1:0]   op_q;
  logic [ROB_ID_W-1:0]   rob_q;
  logic                  kill_q;
  logic                  cdb_valid_q;
  logic [DATA_W-1:0]     ext_result;
  logic [DATA_W-1:0]     wdata_masked;
  logic [2:0]            req_size;

  ls_extend #(.DATA_W(DATA_W)) u_extend (
    .openum_i (op_q),
    .raw_i    (mem_rdata),
    .result_o (ext_result)
  );

  assign req_size = op_size(openum_from_lsb);

  always_comb begin
    wdata_masked = store_data_from_lsb;
    case (req_size)
      3'd1:    wdata_masked = {{(DATA_W-8){1'b0}}, store_data_from_lsb[7:0]};
      3'd2:    wdata_masked = {{(DATA_W-16){1'b0}}, store_data_from_lsb[15:0]};
      default: wdata_masked = store_data_from_lsb;
    endcase
  end

  // Combinational so a registered LSB enable cannot double-book the single slot.
  assign busy_to_lsb = (state_q != IDLE) || enable_from_lsb;
  assign cdb_valid   = cdb_valid_q && !rollback;
  assign dbg_state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rob_q       <= '0;
      kill_q      <= 1'b0;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_size    <= '0;
      mem_wdata   <= '0;
      cdb_valid_q <= 1'b0;
      cdb_rob_id  <= '0;
      cdb_result  <= '0;
    end else if (rdy) begin
      mem_req     <= 1'b0;
      cdb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_from_lsb && !rollback) begin
            op_q      <= openum_from_lsb;
            rob_q     <= rob_id_from_lsb;
            kill_q    <= 1'b0;
            mem_req   <= 1'b1;
            mem_wr    <= !is_load(openum_from_lsb);
            mem_addr  <= addr_from_lsb;
            mem_size  <= req_size;
            mem_wdata <= wdata_masked;
            state_q   <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          // The controller cannot abort, so a flushed load just loses its broadcast.
          if (rollback && is_load(op_q)) kill_q <= 1'b1;
          if (mem_done) begin
            kill_q <= 1'b0;
            if (is_load(op_q) && !kill_q && !rollback) begin
              cdb_valid_q <= 1'b1;
              cdb_rob_id  <= rob_q;
              cdb_result  <= ext_result;
              state_q     <= RESULT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        RESULT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ls_unit.sv
// Directed bench for ls_unit: loads with extension, stores, back-to-back enables,
// rollback kill, stall and mid-transaction reset.
module tb_ls_unit;
  import ls_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        enable_from_lsb = 1'b0;
  logic [5:0]  openum_from_lsb = '0;
  logic [31:0] addr_from_lsb = '0;
  logic [31:0] store_data_from_lsb = '0;
  logic [3:0]  rob_id_from_lsb = '0;
  logic        busy_to_lsb;
  logic        rollback = 1'b0;
  logic        mem_req, mem_wr;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_result;
  state_e      dbg_state;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int req_cnt = 0;
  int req_base;

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_req) req_cnt++;

  ls_unit dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .enable_from_lsb(enable_from_lsb), .openum_from_lsb(openum_from_lsb),
    .addr_from_lsb(addr_from_lsb), .store_data_from_lsb(store_data_from_lsb),
    .rob_id_from_lsb(rob_id_from_lsb), .busy_to_lsb(busy_to_lsb),
    .rollback(rollback), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .cdb_valid(cdb_valid),
    .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; on return the DUT has just latched it.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] id);
    enable_from_lsb     = 1'b1;
    openum_from_lsb     = op;
    addr_from_lsb       = addr;
    store_data_from_lsb = data;
    rob_id_from_lsb     = id;
    #1;
    check("busy_on_enable", 32'(busy_to_lsb), 32'd1);
    tick();
    enable_from_lsb = 1'b0;
  endtask

  // Load with 4-cycle memory latency measured from the mem_req cycle.
  task automatic run_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                          input logic [3:0] id, input logic [2:0] size,
                          input logic [31:0] rdata, input logic [31:0] exp);
    issue(op, addr, 32'h0, id);
    check({tag, "_req"},  32'(mem_req),  32'd1);
    check({tag, "_wr"},   32'(mem_wr),   32'd0);
    check({tag, "_size"}, 32'(mem_size), 32'(size));
    check({tag, "_addr"}, mem_addr,      addr);
    tick(3);
    check({tag, "_req_low"}, 32'(mem_req), 32'd0);
    mem_done  = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_done  = 1'b0;
    mem_rdata = 32'h0;
    check({tag, "_cdb_valid"}, 32'(cdb_valid),  32'd1);
    check({tag, "_cdb_id"},    32'(cdb_rob_id), 32'(id));
    check({tag, "_cdb_res"},   cdb_result,      exp);
    tick();
    check({tag, "_cdb_drop"}, 32'(cdb_valid),   32'd0);
    check({tag, "_idle"},     32'(busy_to_lsb), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_mem_req",   32'(mem_req),     32'd0);
    check("rst_cdb_valid", 32'(cdb_valid),   32'd0);
    check("rst_busy",      32'(busy_to_lsb), 32'd0);
    check("rst_state",     32'(dbg_state),   32'(IDLE));
    check("rst_size",      32'(mem_size),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_load("lw",  OPENUM_LW,  32'h100, 4'd3, 3'd4, 32'hDEADBEEF, 32'hDEADBEEF);
    run_load("lb",  OPENUM_LB,  32'h104, 4'd4, 3'd1, 32'hAB123480, 32'hFFFFFF80);
    run_load("lbu", OPENUM_LBU, 32'h104, 4'd5, 3'd1, 32'hAB123480, 32'h00000080);
    run_load("lh",  OPENUM_LH,  32'h106, 4'd6, 3'd2, 32'h55558001, 32'hFFFF8001);
    run_load("lhu", OPENUM_LHU, 32'h103, 4'd7, 3'd2, 32'h55558001, 32'h00008001);

    // SH: masked write data, no broadcast, free again right after mem_done.
    issue(OPENUM_SH, 32'h200, 32'h12345678, 4'd8);
    check("sh_req",   32'(mem_req),  32'd1);
    check("sh_wr",    32'(mem_wr),   32'd1);
    check("sh_size",  32'(mem_size), 32'd2);
    check("sh_wdata", mem_wdata,     32'h00005678);
    tick(2);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("sh_no_cdb", 32'(cdb_valid),   32'd0);
    check("sh_busy",   32'(busy_to_lsb), 32'd0);

    // SB masks to one byte.
    issue(OPENUM_SB, 32'h201, 32'hCAFEBABE, 4'd9);
    check("sb_size",  32'(mem_size), 32'd1);
    check("sb_wdata", mem_wdata,     32'h000000BE);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("sb_idle", 32'(dbg_state), 32'(IDLE));

    // Two consecutive enables: only the first is taken.
    req_base = req_cnt;
    issue(OPENUM_SW, 32'h300, 32'h0BADF00D, 4'd1);
    enable_from_lsb = 1'b1;
    #1;
    check("dbl_busy2", 32'(busy_to_lsb), 32'd1);
    check("sw_wdata",  mem_wdata,        32'h0BADF00D);
    tick();
    enable_from_lsb = 1'b0;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    tick(2);
    check("dbl_one_req", 32'(req_cnt - req_base), 32'd1);
    check("dbl_idle",    32'(dbg_state),          32'(IDLE));

    // Rollback during WAIT_MEM kills the load broadcast.
    issue(OPENUM_LW, 32'h400, 32'h0, 4'd5);
    tick();
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    check("rb_wait", 32'(dbg_state), 32'(WAIT_MEM));
    tick();
    mem_done  = 1'b1;
    mem_rdata = 32'h11111111;
    tick();
    mem_done = 1'b0;
    check("rb_no_cdb", 32'(cdb_valid), 32'd0);
    check("rb_idle",   32'(dbg_state), 32'(IDLE));
    tick();
    check("rb_no_cdb2", 32'(cdb_valid), 32'd0);
    run_load("rb_next", OPENUM_LW, 32'h404, 4'd6, 3'd4, 32'h13572468, 32'h13572468);

    // Rollback in RESULT suppresses the broadcast combinationally.
    issue(OPENUM_LW, 32'h408, 32'h0, 4'd2);
    mem_done  = 1'b1;
    mem_rdata = 32'h22222222;
    tick();
    mem_done = 1'b0;
    rollback = 1'b1;
    #1;
    check("rb_result_cdb", 32'(cdb_valid), 32'd0);
    tick();
    rollback = 1'b0;
    check("rb_result_idle", 32'(dbg_state), 32'(IDLE));

    // Enable together with rollback in IDLE is dropped.
    rollback = 1'b1;
    enable_from_lsb = 1'b1;
    openum_from_lsb = OPENUM_LW;
    tick();
    rollback = 1'b0;
    enable_from_lsb = 1'b0;
    check("rb_en_drop_req",   32'(mem_req),   32'd0);
    check("rb_en_drop_state", 32'(dbg_state), 32'(IDLE));

    // rdy low: mem_done is not observed.
    issue(OPENUM_LW, 32'h500, 32'h0, 4'd10);
    rdy = 1'b0;
    mem_done = 1'b1;
    mem_rdata = 32'h99999999;
    tick();
    mem_done = 1'b0;
    rdy = 1'b1;
    check("stall_hold", 32'(dbg_state), 32'(WAIT_MEM));
    check("stall_cdb",  32'(cdb_valid), 32'd0);
    mem_done  = 1'b1;
    mem_rdata = 32'h00000077;
    tick();
    mem_done = 1'b0;
    check("stall_cdb_valid", 32'(cdb_valid), 32'd1);
    check("stall_cdb_res",   cdb_result,     32'h00000077);
    tick();

    // Async reset while mem_req is high abandons the transaction.
    issue(OPENUM_LW, 32'h600, 32'h0, 4'd11);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_req",   32'(mem_req),     32'd0);
    check("mrst_addr",  mem_addr,         32'h0);
    check("mrst_size",  32'(mem_size),    32'd0);
    check("mrst_busy",  32'(busy_to_lsb), 32'd0);
    check("mrst_state", 32'(dbg_state),   32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_done  = 1'b1;
    mem_rdata = 32'h44444444;
    tick();
    mem_done = 1'b0;
    check("mrst_no_cdb", 32'(cdb_valid), 32'd0);
    check("mrst_idle",   32'(dbg_state), 32'(IDLE));
    tick();
    check("mrst_no_cdb2", 32'(cdb_valid), 32'd0);
    check("mrst_no_req",  32'(mem_req),   32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
